// File: rtl/nsa_pkg.sv
// Shared constants, FSM encoding and counter sizing for the nibble-serial adder.
package nsa_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // ceil(log2(nibbles)), never less than one bit so a single-nibble build still has a counter
    function automatic int cntWidth(input int nibbles);
        int w;
        w = 0;
        while ((1 << w) < nibbles) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] c;

    assign g = x & y;
    assign p = x ^ y;

    // every carry is a flat sum of products of g/p and ci, none depends on a previous carry
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ {c[3], c[2], c[1], ci};
    assign co = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble per clock, LSB first.
// Optional signed overflow output enabled by defining NIBBLE_SERIAL_SIGNED_OVF_EN.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / NIBBLE;
    localparam int CW = cntWidth(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH < NIBBLE) || ((WIDTH % NIBBLE) != 0)) begin : gWidthCheck
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_e          state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [NIBBLE-1:0] sliceS;
    logic              sliceCo;
    logic [WIDTH-1:0]  aShifted;

    cla4_slice uSlice (
        .x  (aSh_q[NIBBLE-1:0]),
        .y  (bSh_q[NIBBLE-1:0]),
        .ci (carry_q),
        .s  (sliceS),
        .co (sliceCo)
    );

    // partial sums enter the top of the A shifter as its consumed nibbles leave the
    // bottom, so after N shifts that register holds the whole result
    if (N == 1) begin : gOneNibble
        assign aShifted = sliceS;
    end else begin : gMultiNibble
        assign aShifted = {sliceS, aSh_q[WIDTH-1:NIBBLE]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            carry_q <= carry_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        carry_d = carry_q;
        count_d = count_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    aSh_d   = a;
                    bSh_d   = b;
                    carry_d = cin;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                aSh_d   = aShifted;
                bSh_d   = bSh_q >> NIBBLE;
                carry_d = sliceCo;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    sum_d   = aShifted;
                    cout_d  = sliceCo;
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
                    // on the last nibble the operands' sign bits are still at bit 3 of the shifters
                    ovf_d   = (aSh_q[NIBBLE-1] == bSh_q[NIBBLE-1]) && (sliceS[NIBBLE-1] != aSh_q[NIBBLE-1]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // in_ready is deliberately low in DONE: no accept on the same edge a result is consumed
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: 16-bit and 4-bit adders against an arithmetic reference model.
// Checks ovf as well when NIBBLE_SERIAL_SIGNED_OVF_EN is defined.
module tb_nibble_serial_adder;

    localparam int W  = 16;
    localparam int N  = W / 4;

    logic clk = 1'b0;
    logic rst;

    logic         inValid, inReady, outValid, outReady, cinIn, coutOut, busyOut;
    logic [W-1:0] aIn, bIn, sumOut;
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
    logic         ovfOut;
    logic         prevOvf;
`endif

    logic       inValid4, inReady4, outValid4, outReady4, cin4, cout4, busy4;
    logic [3:0] a4, b4, sum4;
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
    logic       ovf4;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] prevSum;
    logic         prevCout;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (aIn),
        .b         (bIn),
        .cin       (cinIn),
        .out_valid (outValid),
        .out_ready (outReady),
        .sum       (sumOut),
        .cout      (coutOut),
        .busy      (busyOut)
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
        ,
        .ovf       (ovfOut)
`endif
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid4),
        .in_ready  (inReady4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (outValid4),
        .out_ready (outReady4),
        .sum       (sum4),
        .cout      (cout4),
        .busy      (busy4)
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
        ,
        .ovf       (ovf4)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference: plain wide addition, carry is whatever spills past bit W-1
    function automatic logic [W:0] refAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic refOvf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] s);
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction

    task automatic waitReady();
        int n = 0;
        while (inReady !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("inReadyTimeout", {63'd0, inReady}, 64'd1);
    endtask

    task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB,
                                 input logic opCin, input int hold);
        logic [W:0] exp;
        int edges;
        waitReady();
        inValid = 1'b1;
        aIn     = opA;
        bIn     = opB;
        cinIn   = opCin;
        @(posedge clk); #1;
        exp = refAdd(opA, opB, opCin);
        edges = 0;
        while (outValid !== 1'b1 && edges < 20) begin
            checkOutput("runState", {44'd0, busyOut, inReady, coutOut, sumOut},
                        {44'd0, 1'b1, 1'b0, prevCout, prevSum});
            inValid = 1'($urandom_range(0, 1));
            aIn     = W'($urandom);
            bIn     = W'($urandom);
            cinIn   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("latency", 64'(edges), 64'(N));
        checkOutput("sum", {48'd0, sumOut}, {48'd0, exp[W-1:0]});
        checkOutput("cout", {63'd0, coutOut}, {63'd0, exp[W]});
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
        checkOutput("ovf", {63'd0, ovfOut}, {63'd0, refOvf(opA, opB, exp[W-1:0])});
        prevOvf = refOvf(opA, opB, exp[W-1:0]);
`endif
        for (int i = 0; i < hold; i++) begin
            inValid = 1'b1;
            aIn     = W'($urandom);
            bIn     = W'($urandom);
            @(posedge clk); #1;
            checkOutput("backpressure", {44'd0, outValid, inReady, busyOut, exp},
                        {44'd0, 1'b1, 1'b0, 1'b1, exp});
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("release", {61'd0, outValid, inReady, busyOut}, {61'd0, 3'b010});
        checkOutput("resultKept", {47'd0, coutOut, sumOut}, {47'd0, exp});
        prevSum  = exp[W-1:0];
        prevCout = exp[W];
    endtask

    task automatic applyStimulusNarrow(input logic [3:0] opA, input logic [3:0] opB, input logic opCin);
        logic [4:0] exp;
        exp = {1'b0, opA} + {1'b0, opB} + {4'd0, opCin};
        checkOutput("w4Ready", {63'd0, inReady4}, 64'd1);
        inValid4 = 1'b1;
        a4       = opA;
        b4       = opB;
        cin4     = opCin;
        @(posedge clk); #1;
        inValid4 = 1'b0;
        checkOutput("w4NotYet", {63'd0, outValid4}, 64'd0);
        @(posedge clk); #1;
        checkOutput("w4Latency", {63'd0, outValid4}, 64'd1);
        checkOutput("w4Result", {59'd0, cout4, sum4}, {59'd0, exp});
        outReady4 = 1'b1;
        @(posedge clk); #1;
        outReady4 = 1'b0;
        checkOutput("w4Release", {62'd0, outValid4, inReady4}, {62'd0, 2'b01});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        inValid   = 1'b0;
        outReady  = 1'b0;
        aIn       = '0;
        bIn       = '0;
        cinIn     = 1'b0;
        inValid4  = 1'b0;
        outReady4 = 1'b0;
        a4        = '0;
        b4        = '0;
        cin4      = 1'b0;
        prevSum   = '0;
        prevCout  = 1'b0;
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
        prevOvf   = 1'b0;
`endif
        #22;
        checkOutput("resetState", {44'd0, outValid, inReady, busyOut, coutOut, sumOut},
                    {44'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        checkOutput("resetState4", {57'd0, outValid4, inReady4, busy4, cout4, sum4},
                    {57'd0, 3'b010, 1'b0, 4'h0});
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
        checkOutput("resetOvf", {62'd0, ovfOut, ovf4}, 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(16'h0001, 16'h0002, 1'b1, 0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 2);
        applyStimulus(16'hAAAA, 16'hCCCC, 1'b1, 1);
        applyStimulus(16'h5A5A, 16'h0F0F, 1'b0, 10);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 0);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 0);

        // reset asserted in the second RUN cycle discards the operation
        waitReady();
        inValid = 1'b1;
        aIn     = 16'hDEAD;
        bIn     = 16'hBEEF;
        cinIn   = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("resetMidRun", {44'd0, outValid, inReady, busyOut, coutOut, sumOut},
                    {44'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
        checkOutput("resetMidRunOvf", {63'd0, ovfOut}, 64'd0);
        prevOvf = 1'b0;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N + 1; i++) begin
            @(posedge clk); #1;
            checkOutput("noPulseAfterReset", {62'd0, outValid, busyOut}, 64'd0);
        end
        prevSum  = '0;
        prevCout = 1'b0;
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1);

        for (int i = 0; i < 24; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        applyStimulusNarrow(4'hF, 4'hF, 1'b1);
        applyStimulusNarrow(4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulusNarrow(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
